// File: rtl/fsm_state_trace.sv
// ---------------------------------------------------------------------------
// fsm_state_trace
//
// Transition trace buffer for an upstream state machine. Every clock it
// samples the machine's 3-bit state code and its y output. Whenever the state
// code differs from the previously sampled one, the new {state, y, stamp}
// is written into a small FIFO. A reader pops entries with rd_en. Two sticky
// flags report dropped entries and illegal state codes.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-high reset
//   state_in   in   [2:0] current state from the upstream FSM
//   y_in       in   upstream y output, sampled together with state_in
//   rd_en      in   read request; pops one entry when the FIFO is non-empty
//   rd_valid   out  one-cycle pulse: rd_state/rd_y/rd_stamp hold a popped entry
//   rd_state   out  [2:0] logged state code
//   rd_y       out  logged y
//   rd_stamp   out  [STAMP_W-1:0] cycle stamp of the logged transition
//   count      out  [$clog2(DEPTH):0] occupancy, 0..DEPTH
//   empty      out  count == 0
//   full       out  count == DEPTH
//   overflow   out  sticky: at least one transition was dropped
//   illegal    out  sticky: an illegal state code was logged
//
// Handshake: rd_en is a request, not a valid/ready pair. A request made in
// the cycle before an edge with count > 0 yields rd_valid = 1 with data after
// that edge; a request while empty is ignored and the rd_* data holds.
// ---------------------------------------------------------------------------
module fsm_state_trace #(
    parameter int          DEPTH       = 8,
    parameter int          STAMP_W     = 8,
    parameter logic [2:0]  RESET_STATE = 3'b000,
    parameter logic [7:0]  LEGAL_MASK  = 8'b0001_1111
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [2:0]               state_in,
    input  logic                     y_in,
    input  logic                     rd_en,
    output logic                     rd_valid,
    output logic [2:0]               rd_state,
    output logic                     rd_y,
    output logic [STAMP_W-1:0]       rd_stamp,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full,
    output logic                     overflow,
    output logic                     illegal
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = 3 + 1 + STAMP_W;

    // Registered state
    logic [2:0]         prev_q;
    logic [STAMP_W-1:0] stamp_q;
    logic [PW-1:0]      wptr_q, wptr_d;
    logic [PW-1:0]      rptr_q, rptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               overflow_q, overflow_d;
    logic               illegal_q, illegal_d;
    logic               rd_valid_q, rd_valid_d;
    logic [EW-1:0]      rd_data_q, rd_data_d;
    logic [EW-1:0]      mem_q [DEPTH];

    // Combinational control
    logic evt;
    logic pop;
    logic push;
    logic drop;
    logic is_full;

    always_comb begin
        evt        = (state_in != prev_q);
        is_full    = (count_q == CW'(DEPTH));
        // No bypass: a read while empty is ignored even if a push arrives.
        pop        = rd_en && (count_q != '0);
        // When full, a push only fits if a pop frees the head in the same cycle.
        push       = evt && (!is_full || pop);
        drop       = evt && is_full && !pop;

        count_d    = count_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        overflow_d = overflow_q | drop;
        illegal_d  = illegal_q | (evt && !LEGAL_MASK[state_in]);
        rd_valid_d = pop;
        rd_data_d  = rd_data_q;

        if (push) begin
            wptr_d = wptr_q + PW'(1);
        end
        if (pop) begin
            rptr_d    = rptr_q + PW'(1);
            rd_data_d = mem_q[rptr_q];
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q     <= RESET_STATE;
            stamp_q    <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            illegal_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            prev_q     <= state_in;
            stamp_q    <= stamp_q + STAMP_W'(1);
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            illegal_q  <= illegal_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    // Storage needs no reset: occupancy and pointers define which entries
    // are live. The stamp logged is the value before this edge's increment.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= {state_in, y_in, stamp_q};
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_state = rd_data_q[EW-1 -: 3];
    assign rd_y     = rd_data_q[STAMP_W];
    assign rd_stamp = rd_data_q[STAMP_W-1:0];
    assign count    = count_q;
    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));
    assign overflow = overflow_q;
    assign illegal  = illegal_q;

endmodule

// File: tb/tb_fsm_state_trace.sv
// ---------------------------------------------------------------------------
// tb_fsm_state_trace
//
// Directed bench for fsm_state_trace with DEPTH=8, STAMP_W=8. Edges are
// numbered from the first rising edge after reset release (edge 1), so the
// stamp logged at edge k is k-1. Expected entries are hand-derived and queued
// in exp_q as {state[2:0], y, stamp[7:0]}.
// ---------------------------------------------------------------------------
module tb_fsm_state_trace;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] state_in;
    logic       y_in;
    logic       rd_en;
    logic       rd_valid;
    logic [2:0] rd_state;
    logic       rd_y;
    logic [7:0] rd_stamp;
    logic [3:0] count;
    logic       empty;
    logic       full;
    logic       overflow;
    logic       illegal;

    always #5 clk = ~clk;

    fsm_state_trace #(
        .DEPTH       (8),
        .STAMP_W     (8),
        .RESET_STATE (3'b000),
        .LEGAL_MASK  (8'b0001_1111)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .state_in (state_in),
        .y_in     (y_in),
        .rd_en    (rd_en),
        .rd_valid (rd_valid),
        .rd_state (rd_state),
        .rd_y     (rd_y),
        .rd_stamp (rd_stamp),
        .count    (count),
        .empty    (empty),
        .full     (full),
        .overflow (overflow),
        .illegal  (illegal)
    );

    // ---------------- scoreboard ----------------
    logic [11:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Advance one rising edge and settle; inputs change and outputs are
    // sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        state_in = 3'd0;
        y_in     = 1'b0;
        rd_en    = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
        check_eq({tag, "_rd_data"},  32'({rd_state, rd_y, rd_stamp}), 32'd0);
        check_eq({tag, "_count"},    32'(count), 32'd0);
        check_eq({tag, "_empty"},    32'(empty), 32'd1);
        check_eq({tag, "_full"},     32'(full), 32'd0);
        check_eq({tag, "_overflow"}, 32'(overflow), 32'd0);
        check_eq({tag, "_illegal"},  32'(illegal), 32'd0);
    endtask

    // Hold rd_en for n edges, comparing each popped entry against exp_q.
    task automatic drain(input string tag, input int n);
        logic [11:0] e;
        rd_en = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick();
            check_eq({tag, "_valid"}, 32'(rd_valid), 32'd1);
            if (exp_q.size() == 0) begin
                check_eq({tag, "_exp_q_underrun"}, 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_eq({tag, "_entry"}, 32'({rd_state, rd_y, rd_stamp}), 32'(e));
            end
        end
        rd_en = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset    = 1'b1;
        state_in = 3'd0;
        y_in     = 1'b0;
        rd_en    = 1'b0;
        #2;
        check_reset_outputs("init");

        // ---- basic trace: 0->1 at edge 3 (y=1), 1->2 at edge 5 (y=0) ----
        do_reset();
        tick();                                  // edge 1
        tick();                                  // edge 2
        state_in = 3'd1; y_in = 1'b1;
        tick();                                  // edge 3, stamp 2
        check_eq("basic_count1", 32'(count), 32'd1);
        tick();                                  // edge 4
        state_in = 3'd2; y_in = 1'b0;
        tick();                                  // edge 5, stamp 4
        check_eq("basic_count2", 32'(count), 32'd2);
        check_eq("basic_empty0", 32'(empty), 32'd0);
        exp_q.push_back({3'd1, 1'b1, 8'd2});
        exp_q.push_back({3'd2, 1'b0, 8'd4});
        drain("basic_drain", 2);
        check_eq("basic_count0", 32'(count), 32'd0);
        check_eq("basic_empty1", 32'(empty), 32'd1);
        // read while empty: no pulse, data holds last entry
        rd_en = 1'b1;
        tick();
        check_eq("basic_empty_rd_valid", 32'(rd_valid), 32'd0);
        check_eq("basic_empty_rd_hold", 32'({rd_state, rd_y, rd_stamp}), 32'({3'd2, 1'b0, 8'd4}));
        check_eq("basic_no_overflow", 32'(overflow), 32'd0);
        rd_en = 1'b0;

        // ---- overflow: 10 events, no reads; first 8 kept ----
        do_reset();
        for (int i = 0; i < 10; i++) begin
            state_in = (i % 2 == 0) ? 3'd1 : 3'd2;
            y_in     = i[0];
            tick();                              // edge i+1, stamp i
            if (i < 8) exp_q.push_back({state_in, y_in, 8'(i)});
            if (i == 7) begin
                check_eq("ovf_full_at8", 32'(full), 32'd1);
                check_eq("ovf_not_yet", 32'(overflow), 32'd0);
            end
        end
        check_eq("ovf_count", 32'(count), 32'd8);
        check_eq("ovf_full", 32'(full), 32'd1);
        check_eq("ovf_flag", 32'(overflow), 32'd1);
        drain("ovf_drain", 8);
        rd_en = 1'b1;
        tick();
        check_eq("ovf_after_drain_valid", 32'(rd_valid), 32'd0);
        check_eq("ovf_after_drain_empty", 32'(empty), 32'd1);
        check_eq("ovf_sticky", 32'(overflow), 32'd1);
        rd_en = 1'b0;

        // ---- simultaneous push/pop while full ----
        do_reset();
        for (int i = 0; i < 8; i++) begin
            state_in = (i % 2 == 0) ? 3'd1 : 3'd2;
            y_in     = 1'b0;
            tick();
            exp_q.push_back({state_in, y_in, 8'(i)});
        end
        check_eq("sim_full", 32'(full), 32'd1);
        state_in = 3'd1; y_in = 1'b1; rd_en = 1'b1;
        tick();                                  // edge 9, stamp 8
        rd_en = 1'b0;
        check_eq("sim_valid", 32'(rd_valid), 32'd1);
        begin
            logic [11:0] e;
            e = exp_q.pop_front();
            check_eq("sim_oldest", 32'({rd_state, rd_y, rd_stamp}), 32'(e));
        end
        exp_q.push_back({3'd1, 1'b1, 8'd8});
        check_eq("sim_count", 32'(count), 32'd8);
        check_eq("sim_no_overflow", 32'(overflow), 32'd0);
        drain("sim_drain", 8);
        check_eq("sim_empty", 32'(empty), 32'd1);

        // ---- illegal state code 6 ----
        do_reset();
        state_in = 3'd6;
        tick();                                  // edge 1, stamp 0
        check_eq("ill_set", 32'(illegal), 32'd1);
        check_eq("ill_count", 32'(count), 32'd1);
        exp_q.push_back({3'd6, 1'b0, 8'd0});
        state_in = 3'd0;
        tick();                                  // edge 2, stamp 1
        exp_q.push_back({3'd0, 1'b0, 8'd1});
        drain("ill_drain", 2);
        tick();
        check_eq("ill_sticky", 32'(illegal), 32'd1);

        // ---- stamp wrap: hold 300 edges, change at edge 301 (stamp 300 mod 256) ----
        do_reset();
        repeat (300) tick();
        state_in = 3'd3; y_in = 1'b1;
        tick();
        exp_q.push_back({3'd3, 1'b1, 8'd44});
        drain("wrap_drain", 1);
        rd_en = 1'b1;
        tick();
        check_eq("wrap_empty_rd_valid", 32'(rd_valid), 32'd0);
        check_eq("wrap_no_illegal", 32'(illegal), 32'd0);
        rd_en = 1'b0;

        // ---- asynchronous reset mid-operation ----
        do_reset();
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: state_in = 3'd7;
                1: state_in = 3'd1;
                2: state_in = 3'd2;
                3: state_in = 3'd1;
                default: state_in = 3'd2;
            endcase
            tick();
        end
        check_eq("rst_pre_count", 32'(count), 32'd5);
        check_eq("rst_pre_illegal", 32'(illegal), 32'd1);
        rd_en = 1'b1;
        tick();                                  // one pop in flight
        check_eq("rst_pre_valid", 32'(rd_valid), 32'd1);
        #2;
        reset = 1'b1;                            // mid-cycle, no clock edge
        #1;
        check_reset_outputs("rst_async");
        state_in = 3'd0; rd_en = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick();                                  // edge 1
        tick();                                  // edge 2
        state_in = 3'd4;
        tick();                                  // edge 3, stamp 2
        check_eq("rst_post_count", 32'(count), 32'd1);
        exp_q.push_back({3'd4, 1'b0, 8'd2});
        drain("rst_post_drain", 1);

        // ---------------- final report ----------------
        if (exp_q.size() != 0) begin
            check_eq("exp_q_leftover", 32'(exp_q.size()), 32'd0);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
